mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_align.sv | 64 ++++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Package common: memory access types and arbiter enums.
// Shared by mem_arbiter and mem_align.
package common;

    typedef enum logic [3:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LH   = 4'd2,
        LW   = 4'd3,
        LBU  = 4'd4,
        LHU  = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } mem_access_type;

    typedef enum logic {
        IFETCH = 1'b0,
        DATA   = 1'b1
    } arb_owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane strobes, write replication, load extension and
// misalignment detection for one memory access.
import common::*;

module mem_align (
    input  mem_access_type acc,
    input  logic [1:0]     off,
    input  logic [31:0]    wdata,
    input  logic [31:0]    rdata,
    output logic           we,
    output logic [3:0]     wstrb,
    output logic [31:0]    wdata_lane,
    output logic [31:0]    rdata_ext,
    output logic           misaligned
);

    logic [31:0] byte_v;
    logic [31:0] half_v;

    assign byte_v = rdata >> {off, 3'b000};
    assign half_v = rdata >> {off[1], 4'b0000};

    always_comb begin
        we         = 1'b0;
        wstrb      = 4'b0000;
        wdata_lane = wdata;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        unique case (1'b1)
            acc == LB:  rdata_ext = {{24{byte_v[7]}}, byte_v[7:0]};
            acc == LBU: rdata_ext = {24'h0, byte_v[7:0]};
            acc == LH: begin
                misaligned = off[0];
                rdata_ext  = {{16{half_v[15]}}, half_v[15:0]};
            end
            acc == LHU: begin
                misaligned = off[0];
                rdata_ext  = {16'h0, half_v[15:0]};
            end
            acc == LW: begin
                misaligned = |off;
                rdata_ext  = rdata;
            end
            acc == SB: begin
                we         = 1'b1;
                wstrb      = 4'b0001 << off;
                wdata_lane = {4{wdata[7:0]}};
            end
            acc == SH: begin
                we         = 1'b1;
                misaligned = off[0];
                wstrb      = 4'b0011 << off;
                wdata_lane = {2{wdata[15:0]}};
            end
            acc == SW: begin
                we         = 1'b1;
                misaligned = |off;
                wstrb      = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto one single-outstanding memory port.
// Define MEM_ARB_FAIR_EN for round-robin instead of data priority.
import common::*;

module mem_arbiter (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_req,
    input  logic [31:0]    if_addr,
    output logic           if_gnt,
    output logic           if_rvalid,
    output logic [31:0]    if_rdata,
    input  logic           d_req,
    input  mem_access_type d_access_type,
    input  logic [31:0]    d_addr,
    input  logic [31:0]    d_wdata,
    output logic           d_gnt,
    output logic           d_rvalid,
    output logic [31:0]    d_rdata,
    output logic           d_err,
    output logic           mem_req,
    output logic           mem_we,
    output logic [31:0]    mem_addr,
    output logic [3:0]     mem_wstrb,
    output logic [31:0]    mem_wdata,
    input  logic           mem_ack,
    input  logic [31:0]    mem_rdata
);

    arb_state_t     state;
    arb_owner_t     owner;
    mem_access_type cap_type;
    logic [1:0]     cap_off;
    logic           pick_d;

`ifdef MEM_ARB_FAIR_EN
    arb_owner_t ptr;
    assign pick_d = d_req && (!if_req || ptr == DATA);
`else
    assign pick_d = d_req;
`endif

    assign d_gnt  = !rst && state == IDLE && pick_d;
    assign if_gnt = !rst && state == IDLE && if_req && !pick_d;

    // Live request fields at grant, captured fields while waiting.
    mem_access_type a_type;
    logic [31:0]    a_addr;
    logic           a_we;
    logic [3:0]     a_wstrb;
    logic [31:0]    a_wdata;
    logic [31:0]    a_rdata;
    logic           a_mis;

    always_comb begin
        a_type = cap_type;
        a_addr = {30'h0, cap_off};
        if (state == IDLE) begin
            a_type = pick_d ? d_access_type : LW;
            a_addr = pick_d ? d_addr : if_addr;
        end
    end

    mem_align u_align (
        .acc        (a_type),
        .off        (a_addr[1:0]),
        .wdata      (d_wdata),
        .rdata      (mem_rdata),
        .we         (a_we),
        .wstrb      (a_wstrb),
        .wdata_lane (a_wdata),
        .rdata_ext  (a_rdata),
        .misaligned (a_mis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= IFETCH;
            cap_type  <= NONE;
            cap_off   <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            if_rvalid <= 1'b0;
            if_rdata  <= 32'h0;
            d_rvalid  <= 1'b0;
            d_rdata   <= 32'h0;
            d_err     <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            ptr       <= DATA;
`endif
        end else begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            d_err     <= 1'b0;
            unique case (state)
                IDLE: if (d_gnt || if_gnt) begin
                    owner    <= pick_d ? DATA : IFETCH;
                    cap_type <= a_type;
                    cap_off  <= a_addr[1:0];
`ifdef MEM_ARB_FAIR_EN
                    ptr      <= pick_d ? IFETCH : DATA;
`endif
                    if (pick_d && a_mis) begin
                        state <= ERR;
                    end else begin
                        state     <= WAIT;
                        mem_req   <= 1'b1;
                        mem_we    <= a_we;
                        mem_addr  <= {a_addr[31:2], 2'b00};
                        mem_wstrb <= a_wstrb;
                        mem_wdata <= a_wdata;
                    end
                end
                WAIT: if (mem_ack) begin
                    state     <= IDLE;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 4'h0;
                    if (owner == DATA) begin
                        d_rvalid <= 1'b1;
                        d_rdata  <= a_rdata;
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= mem_rdata;
                    end
                end
                ERR: begin
                    state    <= IDLE;
                    d_rvalid <= 1'b1;
                    d_err    <= 1'b1;
                    d_rdata  <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
